// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions for the MEM/WB pipeline stages: memory sizing, write-back
// source encodings and the bubble contents of the stage registers.
package mem_wb_stage_pkg;

  localparam int DMEM_DEPTH_DEFAULT = 256;

  localparam logic       SWD_ALU  = 1'b0;
  localparam logic       SWD_MEM  = 1'b1;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        dmem_we;
    logic        reg_we;
    logic        swd;
    logic [4:0]  wra;
    logic [31:0] alu_out;
    logic [31:0] store_data;
  } mem_stage_t;

  typedef struct packed {
    logic        reg_we;
    logic        swd;
    logic [4:0]  wra;
    logic [31:0] alu_out;
  } wb_stage_t;

  localparam mem_stage_t MEM_BUBBLE = '{
    dmem_we:    1'b0,
    reg_we:     1'b0,
    swd:        SWD_ALU,
    wra:        REG_ZERO,
    alu_out:    32'h0000_0000,
    store_data: 32'h0000_0000
  };

  localparam wb_stage_t WB_BUBBLE = '{
    reg_we:  1'b0,
    swd:     SWD_ALU,
    wra:     REG_ZERO,
    alu_out: 32'h0000_0000
  };

  // R0 is hardwired, so a write to it is never a real register-file write.
  function automatic logic writes_reg(input logic reg_we, input logic [4:0] wra);
    return reg_we && (wra != REG_ZERO);
  endfunction

endpackage

// File: rtl/mem_wb_stage_dmem.sv
// Single-port data memory: synchronous write, synchronous read, contents not reset.
module mem_wb_stage_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Write on enable; read data is captured every edge (old data on a write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata_r <= mem_r[addr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB pipeline registers around the data memory, with MEM-stage forwarding
// and load-use indication for the hazard unit.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_MEM_dmemWe,
  input  logic        i_MEM_regWe,
  input  logic        i_MEM_sWD,
  input  logic [4:0]  i_MEM_WRA,
  input  logic [31:0] i_MEM_ALUout,
  input  logic [31:0] i_MEM_storeData,
  input  logic        i_MEM_stall,
  input  logic        i_MEM_flush,
  output logic        o_MEM_fwdValid,
  output logic [4:0]  o_MEM_fwdWRA,
  output logic [31:0] o_MEM_fwdData,
  output logic        o_MEM_loadUse,
  output logic        o_WB_regWe,
  output logic [4:0]  o_WB_WRA,
  output logic [31:0] o_WB_WD
);

  localparam int AW = $clog2(DMEM_DEPTH);

  mem_stage_t  mem_r;
  wb_stage_t   wb_r;
  logic        stall_eff_s;
  logic        dmem_we_s;
  logic [AW-1:0] dmem_addr_s;
  logic [31:0] dmem_rdata_s;
  logic        unused_addr_bits_s;

  // A flush overrides a stall: the MEM instruction still advances into WB.
  assign stall_eff_s = i_MEM_stall & ~i_MEM_flush;

  // MEM register: bubble on reset or flush, hold on stall, otherwise capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_r <= MEM_BUBBLE;
    end else if (i_MEM_flush) begin
      mem_r <= MEM_BUBBLE;
    end else if (!i_MEM_stall) begin
      mem_r <= '{
        dmem_we:    i_MEM_dmemWe,
        reg_we:     i_MEM_regWe,
        swd:        i_MEM_sWD,
        wra:        i_MEM_WRA,
        alu_out:    i_MEM_ALUout,
        store_data: i_MEM_storeData
      };
    end else begin
      mem_r <= mem_r;
    end
  end

  // WB register: a stalled MEM stage sends a bubble down; R0 writes are dropped here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_r <= WB_BUBBLE;
    end else if (stall_eff_s) begin
      wb_r <= WB_BUBBLE;
    end else begin
      wb_r <= '{
        reg_we:  writes_reg(mem_r.reg_we, mem_r.wra),
        swd:     mem_r.swd,
        wra:     mem_r.wra,
        alu_out: mem_r.alu_out
      };
    end
  end

  assign dmem_we_s   = rstn & mem_r.dmem_we & ~stall_eff_s;
  assign dmem_addr_s = mem_r.alu_out[AW+1:2];
  assign unused_addr_bits_s = ^{mem_r.alu_out[31:AW+2], mem_r.alu_out[1:0]};

  mem_wb_stage_dmem #(
    .DEPTH (DMEM_DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk   (clk),
    .we    (dmem_we_s),
    .addr  (dmem_addr_s),
    .wdata (mem_r.store_data),
    .rdata (dmem_rdata_s)
  );

  assign o_MEM_fwdValid = writes_reg(mem_r.reg_we, mem_r.wra) && (mem_r.swd == SWD_ALU);
  assign o_MEM_fwdWRA   = mem_r.wra;
  assign o_MEM_fwdData  = mem_r.alu_out;
  assign o_MEM_loadUse  = writes_reg(mem_r.reg_we, mem_r.wra) && (mem_r.swd == SWD_MEM);

  assign o_WB_regWe = wb_r.reg_we;
  assign o_WB_WRA   = wb_r.wra;
  assign o_WB_WD    = (wb_r.swd == SWD_MEM) ? dmem_rdata_s : wb_r.alu_out;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for the pipelined flow, then
// hand-written stall and mid-store reset sequences.
module tb_mem_wb_stage;

  logic        clk;
  logic        rstn;
  logic        dmem_we, reg_we, swd, stall, flush;
  logic [4:0]  wra;
  logic [31:0] alu, sdata;
  logic        fwd_valid, load_use, wb_regwe;
  logic [4:0]  fwd_wra, wb_wra;
  logic [31:0] fwd_data, wb_wd;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  typedef struct {
    logic        dwe, rwe, swd;
    logic [4:0]  wra;
    logic [31:0] alu, sdata;
    logic        stall, flush;
    logic        e_fv;
    logic [4:0]  e_fwra;
    logic [31:0] e_fdata;
    logic        e_lu, e_we;
    logic [4:0]  e_wra;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs [12];

  mem_wb_stage #(.DMEM_DEPTH(256)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_MEM_dmemWe    (dmem_we),
    .i_MEM_regWe     (reg_we),
    .i_MEM_sWD       (swd),
    .i_MEM_WRA       (wra),
    .i_MEM_ALUout    (alu),
    .i_MEM_storeData (sdata),
    .i_MEM_stall     (stall),
    .i_MEM_flush     (flush),
    .o_MEM_fwdValid  (fwd_valid),
    .o_MEM_fwdWRA    (fwd_wra),
    .o_MEM_fwdData   (fwd_data),
    .o_MEM_loadUse   (load_use),
    .o_WB_regWe      (wb_regwe),
    .o_WB_WRA        (wb_wra),
    .o_WB_WD         (wb_wd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_fv, input logic [4:0] e_fwra,
                           input logic [31:0] e_fdata, input logic e_lu, input logic e_we,
                           input logic [4:0] e_wra, input logic [31:0] e_wd);
    check({tag, ".fwdValid"}, {31'd0, fwd_valid}, {31'd0, e_fv});
    check({tag, ".fwdWRA"},   {27'd0, fwd_wra},   {27'd0, e_fwra});
    check({tag, ".fwdData"},  fwd_data,           e_fdata);
    check({tag, ".loadUse"},  {31'd0, load_use},  {31'd0, e_lu});
    check({tag, ".wbRegWe"},  {31'd0, wb_regwe},  {31'd0, e_we});
    check({tag, ".wbWRA"},    {27'd0, wb_wra},    {27'd0, e_wra});
    check({tag, ".wbWD"},     wb_wd,              e_wd);
  endtask

  task automatic drive(input logic d, input logic r, input logic s, input logic [4:0] a,
                       input logic [31:0] al, input logic [31:0] sd, input logic st, input logic fl);
    dmem_we = d; reg_we = r; swd = s; wra = a; alu = al; sdata = sd; stall = st; flush = fl;
  endtask

  // Count cycles whose edge would write memory, then advance one edge.
  task automatic step();
    if (dut.dmem_we_s === 1'b1) wr_count++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          dwe  rwe  swd  wra    alu            sdata          st   fl    fv   fwra   fdata          lu   we   wra    wd
    vecs[0]  = '{1'b1,1'b0,1'b0,5'd0,32'h0000_0010,32'hDEAD_BEEF,1'b0,1'b0, 1'b0,5'd0,32'h0000_0010,1'b0,1'b0,5'd0,32'h0000_0000};
    vecs[1]  = '{1'b0,1'b1,1'b1,5'd5,32'h0000_0010,32'h0000_0000,1'b0,1'b0, 1'b0,5'd5,32'h0000_0010,1'b1,1'b0,5'd0,32'h0000_0010};
    vecs[2]  = '{1'b0,1'b1,1'b0,5'd3,32'h0000_1234,32'h0000_0000,1'b0,1'b0, 1'b1,5'd3,32'h0000_1234,1'b0,1'b1,5'd5,32'hDEAD_BEEF};
    vecs[3]  = '{1'b0,1'b1,1'b0,5'd0,32'h0000_0055,32'h0000_0000,1'b0,1'b0, 1'b0,5'd0,32'h0000_0055,1'b0,1'b1,5'd3,32'h0000_1234};
    vecs[4]  = '{1'b0,1'b1,1'b1,5'd7,32'h0000_0013,32'h0000_0000,1'b0,1'b0, 1'b0,5'd7,32'h0000_0013,1'b1,1'b0,5'd0,32'h0000_0055};
    vecs[5]  = '{1'b0,1'b0,1'b0,5'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0, 1'b0,5'd0,32'h0000_0000,1'b0,1'b1,5'd7,32'hDEAD_BEEF};
    vecs[6]  = '{1'b1,1'b0,1'b0,5'd0,32'h0000_0420,32'hCAFE_F00D,1'b0,1'b0, 1'b0,5'd0,32'h0000_0420,1'b0,1'b0,5'd0,32'h0000_0000};
    vecs[7]  = '{1'b0,1'b1,1'b1,5'd9,32'h0000_0020,32'h0000_0000,1'b0,1'b0, 1'b0,5'd9,32'h0000_0020,1'b1,1'b0,5'd0,32'h0000_0420};
    vecs[8]  = '{1'b0,1'b0,1'b0,5'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0, 1'b0,5'd0,32'h0000_0000,1'b0,1'b1,5'd9,32'hCAFE_F00D};
    vecs[9]  = '{1'b1,1'b0,1'b0,5'd0,32'h0000_0020,32'h9999_9999,1'b0,1'b1, 1'b0,5'd0,32'h0000_0000,1'b0,1'b0,5'd0,32'h0000_0000};
    vecs[10] = '{1'b0,1'b1,1'b1,5'd2,32'h0000_0020,32'h0000_0000,1'b0,1'b0, 1'b0,5'd2,32'h0000_0020,1'b1,1'b0,5'd0,32'h0000_0000};
    vecs[11] = '{1'b0,1'b0,1'b0,5'd0,32'h0000_0000,32'h0000_0000,1'b0,1'b0, 1'b0,5'd0,32'h0000_0000,1'b0,1'b1,5'd2,32'hCAFE_F00D};

    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    step();
    check_all("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].dwe, vecs[i].rwe, vecs[i].swd, vecs[i].wra, vecs[i].alu,
            vecs[i].sdata, vecs[i].stall, vecs[i].flush);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_fv, vecs[i].e_fwra, vecs[i].e_fdata,
                vecs[i].e_lu, vecs[i].e_we, vecs[i].e_wra, vecs[i].e_wd);
    end

    // Store held three cycles by a stall, then released; a load follows it.
    wr_count = 0;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0030, 32'h0000_AAAA, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0030, 32'h0000_0000, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d.wbRegWe", c), {31'd0, wb_regwe}, 32'd0);
      check($sformatf("stall%0d.heldAddr", c), fwd_data, 32'h0000_0030);
    end
    stall = 1'b0;
    step();
    check_all("release", 1'b0, 5'd4, 32'h0000_0030, 1'b1, 1'b0, 5'd0, 32'h0000_0030);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    check_all("stallLoad", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd4, 32'h0000_AAAA);
    check("stall.writeCount", wr_count, 32'd1);

    // Reset pulse while a store to 0x10 sits in MEM: it must never land.
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0010, 32'h1234_5678, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    check_all("midReset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check_all("heldReset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    rstn = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0010, 32'd0, 1'b0, 1'b0);
    step();
    check_all("postReset", 1'b0, 5'd6, 32'h0000_0010, 1'b1, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    check_all("keptValue", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd6, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DMEM_DEPTH, default 256, meaning the number of 32-bit data-memory words (power of 2, minimum 4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_MEM_dmemWe, input, 1 bit: the incoming instruction is a store.
REQ-005 SHALL have port i_MEM_regWe, input, 1 bit: the incoming instruction writes the register file.
REQ-006 SHALL have port i_MEM_sWD, input, 1 bit: write-back source select (1 = data-memory read data, i.e. load; 0 = ALU result).
REQ-007 SHALL have port i_MEM_WRA, input, 5 bits: destination register address.
REQ-008 SHALL have port i_MEM_ALUout, input, 32 bits: ALU result, also the byte address for loads and stores.
REQ-009 SHALL have port i_MEM_storeData, input, 32 bits: store data.
REQ-010 SHALL have port i_MEM_stall, input, 1 bit: hold the MEM stage.
REQ-011 SHALL have port i_MEM_flush, input, 1 bit: replace the incoming instruction with a bubble.
REQ-012 SHALL have ports o_MEM_fwdValid (1 bit), o_MEM_fwdWRA (5 bits) and o_MEM_fwdData (32 bits), outputs: MEM-stage forwarding.
REQ-013 SHALL have port o_MEM_loadUse, output, 1 bit: the MEM stage holds a load that has a nonzero destination.
REQ-014 SHALL have ports o_WB_regWe (1 bit), o_WB_WRA (5 bits) and o_WB_WD (32 bits), outputs: the register-file write port.

Function
REQ-015 SHALL be two register stages, MEM and WB; inputs present at edge k appear on the o_WB_* outputs after edge k+1 (latency of 2 edges).
REQ-016 SHALL load the MEM register with all-zero fields (a bubble) when i_MEM_flush=1, regardless of i_MEM_stall.
REQ-017 SHALL, when i_MEM_stall=1 and i_MEM_flush=0, hold the MEM register unchanged, suppress the data-memory write, and load the WB register with a bubble (regWe=0).
REQ-018 SHALL otherwise capture all inputs into the MEM register on each edge.
REQ-019 SHALL compute the word address as MEM ALUout[log2(DMEM_DEPTH)+1:2]; upper address bits wrap silently and bits [1:0] are ignored (no misalignment trap).
REQ-020 SHALL write store data to the data memory at the edge that advances a non-stalled MEM-stage instruction whose dmemWe=1.
REQ-021 SHALL read the data memory synchronously at the same edge that loads the WB register.
REQ-022 SHALL make a load in the MEM stage immediately following a store to the same address return the newly stored data.
REQ-023 SHALL drive o_WB_WD from the registered data-memory read data when WB sWD=1, and from the registered ALUout otherwise.
REQ-024 SHALL force o_WB_regWe to 0 whenever o_WB_WRA = 0.
REQ-025 SHALL assert o_MEM_fwdValid only when MEM regWe=1, sWD=0 and WRA≠0; o_MEM_fwdData SHALL equal MEM ALUout and o_MEM_fwdWRA SHALL equal MEM WRA.
REQ-026 SHALL assert o_MEM_loadUse when MEM regWe=1, sWD=1 and WRA≠0.
REQ-027 SHALL perform no register-file write and no data-memory write for a bubble.

Reset
REQ-028 SHALL, while rstn=0, clear the MEM and WB registers to zero, so all outputs read 0, with no data-memory write permitted.
REQ-029 SHALL NOT reset data-memory contents; contents are undefined until written.
REQ-030 SHALL, when reset is asserted mid-operation, abort any pending store (no write) and start from bubbles at the first edge after rstn rises.

Structure
REQ-031 SHALL take DMEM_DEPTH default, the bubble field values and the sWD encodings from a shared CPU package, reused by the EXE stage and the hazard unit.
REQ-032 SHALL implement the data memory as one sub-module, dmem: synchronous write, synchronous read, one port.

Verification
REQ-033 SHALL cover: store 0xDEADBEEF to address 0x10, then load from 0x10 into R5 on the next cycle -> o_WB_regWe=1, WRA=5, WD=0xDEADBEEF, 2 edges after the load enters.
REQ-034 SHALL cover: ALU op with ALUout=0x1234, regWe=1, WRA=3, sWD=0 -> o_MEM_fwdValid=1 and fwdData=0x1234 after 1 edge, then o_WB_WD=0x1234 after 2 edges.
REQ-035 SHALL cover: i_MEM_stall held 3 cycles with a store in the MEM stage -> a single memory write once released, and WB regWe=0 during the stall.
REQ-036 SHALL cover: i_MEM_flush=1 together with a store to 0x20 -> memory at 0x20 unchanged and o_WB_regWe=0.
REQ-037 SHALL cover: regWe=1 with WRA=0 -> o_WB_regWe=0; and a load to R7 in the MEM stage -> o_MEM_loadUse=1 and o_MEM_fwdValid=0.
REQ-038 SHALL cover: rstn pulsed low mid-store -> all outputs 0 immediately, and the stored address keeps its prior value.
